// File: rtl/alu_logic_checker_pkg.sv
// ---------------------------------------------------------------------------
// alu_logic_pkg
// Shared types and defaults for the ALU logical-unit response checker.
//   op_e    : logical operation encoding carried on in_op
//   state_e : checker run-control FSM states
//   DEF_WIDTH / DEF_CNT_W : default operand width and counter width
// ---------------------------------------------------------------------------
package alu_logic_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_logic_checker_if.sv
// ---------------------------------------------------------------------------
// alu_logic_checker_if
// Vector stream from the ALU logical unit capture point into the checker.
//   in_valid  : vector present (master -> slave)
//   in_ready  : checker accepts vector (slave -> master)
//   in_op     : operation, see alu_logic_pkg::op_e
//   in_a/in_b : operands
//   in_result : result under test
// Modports: master = vector source, slave = checker.
// ---------------------------------------------------------------------------
interface alu_logic_checker_if #(
  parameter int WIDTH = alu_logic_pkg::DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_result;

  modport master (
    output in_valid, in_op, in_a, in_b, in_result,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_result,
    output in_ready
  );
endinterface

// File: rtl/alu_logic_checker_ref_model.sv
// ---------------------------------------------------------------------------
// alu_logic_ref_model
// Combinational reference for the ALU logical unit: (op, a, b) -> expected.
//   op       : in  2      operation (alu_logic_pkg::op_e encoding)
//   a, b     : in  WIDTH  operands
//   expected : out WIDTH  reference result
// ---------------------------------------------------------------------------
module alu_logic_ref_model
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] expected
);

  always_comb begin
    expected = '0;
    case (op_e'(op))
      OP_AND:  expected = a & b;
      OP_OR:   expected = a | b;
      OP_XOR:  expected = a ^ b;
      OP_NOR:  expected = ~(a | b);
      default: expected = '0;
    endcase
  end

endmodule

// File: rtl/alu_logic_checker.sv
// ---------------------------------------------------------------------------
// alu_logic_checker
// Response checker for the ALU logical units. Accepts operand/result vectors,
// recomputes the expected value, counts mismatches and reports pass/fail per
// run of num_vec vectors.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle pulse, begins a run (ignored while running)
//   num_vec     : vectors in the run, sampled on start
//   vec_if      : vector stream (slave side)
//   busy / done / pass : run status (done and pass held until next start)
//   err_count   : saturating mismatch count; vec_count : vectors accepted
//   ff_*        : first-failure capture (index, expected, actual)
// Build option: define ALU_CHK_FIRST_FAIL_EN to build the first-failure
// capture registers; otherwise all ff_* outputs are tied to 0.
// ---------------------------------------------------------------------------
module alu_logic_checker
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_vec,
  alu_logic_checker_if.slave  vec_if,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]    vec_count,
  output logic                ff_valid,
  output logic [CNT_W-1:0]    ff_index,
  output logic [WIDTH-1:0]    ff_expected,
  output logic [WIDTH-1:0]    ff_actual
);

  state_e           state_reg;
  state_e           state_next;
  logic [CNT_W-1:0] num_vec_reg;
  logic [CNT_W-1:0] vec_count_reg;
  logic [CNT_W-1:0] err_count_reg;
  logic [CNT_W-1:0] vec_count_next;
  logic [WIDTH-1:0] expected;
  logic             start_ok;
  logic             xfer;
  logic             mismatch;
  logic             last_xfer;

  alu_logic_ref_model #(.WIDTH(WIDTH)) u_ref (
    .op       (vec_if.in_op),
    .a        (vec_if.in_a),
    .b        (vec_if.in_b),
    .expected (expected)
  );

  // A start pulse is only honoured outside RUN.
  assign start_ok       = start && (state_reg != ST_RUN);
  assign xfer           = vec_if.in_valid && (state_reg == ST_RUN);
  assign mismatch       = (expected != vec_if.in_result);
  assign vec_count_next = vec_count_reg + CNT_W'(1);
  assign last_xfer      = xfer && (vec_count_next == num_vec_reg);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_next = (num_vec == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_xfer) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state; all 0 in IDLE, hence 0 out of reset.
  always_comb begin
    vec_if.in_ready = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    pass            = 1'b0;
    case (state_reg)
      ST_RUN: begin
        vec_if.in_ready = 1'b1;
        busy            = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
        pass = (err_count_reg == '0);
      end
      default: ;
    endcase
  end

  // Run length and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_vec_reg   <= '0;
      vec_count_reg <= '0;
      err_count_reg <= '0;
    end else if (start_ok) begin
      num_vec_reg   <= num_vec;
      vec_count_reg <= '0;
      err_count_reg <= '0;
    end else if (xfer) begin
      vec_count_reg <= vec_count_next;
      // Saturate rather than wrap so a long bad run never reads as clean.
      if (mismatch && (err_count_reg != '1)) begin
        err_count_reg <= err_count_reg + CNT_W'(1);
      end
    end
  end

  assign err_count = err_count_reg;
  assign vec_count = vec_count_reg;

`ifdef ALU_CHK_FIRST_FAIL_EN
  logic             ff_valid_reg;
  logic [CNT_W-1:0] ff_index_reg;
  logic [WIDTH-1:0] ff_expected_reg;
  logic [WIDTH-1:0] ff_actual_reg;

  // Capture only the first mismatch of a run; ff_valid_reg blocks later ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid_reg    <= 1'b0;
      ff_index_reg    <= '0;
      ff_expected_reg <= '0;
      ff_actual_reg   <= '0;
    end else if (start_ok) begin
      ff_valid_reg    <= 1'b0;
      ff_index_reg    <= '0;
      ff_expected_reg <= '0;
      ff_actual_reg   <= '0;
    end else if (xfer && mismatch && !ff_valid_reg) begin
      ff_valid_reg    <= 1'b1;
      ff_index_reg    <= vec_count_reg;
      ff_expected_reg <= expected;
      ff_actual_reg   <= vec_if.in_result;
    end
  end

  assign ff_valid    = ff_valid_reg;
  assign ff_index    = ff_index_reg;
  assign ff_expected = ff_expected_reg;
  assign ff_actual   = ff_actual_reg;
`else
  assign ff_valid    = 1'b0;
  assign ff_index    = '0;
  assign ff_expected = '0;
  assign ff_actual   = '0;
`endif

endmodule

// File: tb/tb_alu_logic_checker.sv
// ---------------------------------------------------------------------------
// tb_alu_logic_checker
// Directed, table-driven bench for alu_logic_checker. A 16-bit-counter
// instance runs the vector tables, zero-length, reset and mid-run start
// sequences; a 4-bit-counter instance runs the all-mismatch saturation run.
// ---------------------------------------------------------------------------
module tb_alu_logic_checker;
  import alu_logic_pkg::*;

  localparam int W  = 64;
  localparam int CW = 16;
  localparam int SW = 4;

`ifdef ALU_CHK_FIRST_FAIL_EN
  localparam bit FFEN = 1'b1;
`else
  localparam bit FFEN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (CNT_W = 16)
  logic          start   = 1'b0;
  logic [CW-1:0] num_vec = '0;
  logic          busy, done, pass, ff_valid;
  logic [CW-1:0] err_count, vec_count, ff_index;
  logic [W-1:0]  ff_expected, ff_actual;

  alu_logic_checker_if #(.WIDTH(W)) vif ();

  alu_logic_checker #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_vec     (num_vec),
    .vec_if      (vif),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .vec_count   (vec_count),
    .ff_valid    (ff_valid),
    .ff_index    (ff_index),
    .ff_expected (ff_expected),
    .ff_actual   (ff_actual)
  );

  // Small-counter instance (CNT_W = 4)
  logic          s_start   = 1'b0;
  logic [SW-1:0] s_num_vec = '0;
  logic          s_busy, s_done, s_pass, s_ff_valid;
  logic [SW-1:0] s_err_count, s_vec_count, s_ff_index;
  logic [W-1:0]  s_ff_expected, s_ff_actual;

  alu_logic_checker_if #(.WIDTH(W)) sif ();

  alu_logic_checker #(.WIDTH(W), .CNT_W(SW)) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (s_start),
    .num_vec     (s_num_vec),
    .vec_if      (sif),
    .busy        (s_busy),
    .done        (s_done),
    .pass        (s_pass),
    .err_count   (s_err_count),
    .vec_count   (s_vec_count),
    .ff_valid    (s_ff_valid),
    .ff_index    (s_ff_index),
    .ff_expected (s_ff_expected),
    .ff_actual   (s_ff_actual)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  res;
    logic [CW-1:0] exp_err;   // err_count after this transfer
  } vec_t;

  typedef struct {
    int            n;
    int            first;
    bit            toggle;    // idle cycle between transfers
    logic [CW-1:0] exp_err;
    bit            exp_pass;
    bit            ffv;
    logic [CW-1:0] ffi;
    logic [W-1:0]  ffe;
    logic [W-1:0]  ffa;
  } run_t;

  vec_t vt[9];
  run_t rt[3];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},        W'(busy),        '0);
    chk({tag, "_done"},        W'(done),        '0);
    chk({tag, "_pass"},        W'(pass),        '0);
    chk({tag, "_in_ready"},    W'(vif.in_ready), '0);
    chk({tag, "_err_count"},   W'(err_count),   '0);
    chk({tag, "_vec_count"},   W'(vec_count),   '0);
    chk({tag, "_ff_valid"},    W'(ff_valid),    '0);
    chk({tag, "_ff_index"},    W'(ff_index),    '0);
    chk({tag, "_ff_expected"}, ff_expected,     '0);
    chk({tag, "_ff_actual"},   ff_actual,       '0);
  endtask

  task automatic drive_vec(input vec_t v);
    vif.in_valid  = 1'b1;
    vif.in_op     = v.op;
    vif.in_a      = v.a;
    vif.in_b      = v.b;
    vif.in_result = v.res;
  endtask

  task automatic drive_idle();
    vif.in_valid  = 1'b0;
    vif.in_op     = 2'($urandom_range(0, 3));
    vif.in_a      = {$urandom, $urandom};
    vif.in_b      = {$urandom, $urandom};
    vif.in_result = {$urandom, $urandom};
  endtask

  initial begin
    // op, a, b, result, err_count after transfer (expected op value noted)
    vt[0] = '{2'b00, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'h0, 16'd0};                    // AND -> 0
    vt[1] = '{2'b00, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 16'd0};  // AND -> A..A
    vt[2] = '{2'b10, 64'hF0F0_F0F0_F0F0_F0F0, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0, 16'd0};                    // XOR -> 0
    vt[3] = '{2'b10, 64'h1234, 64'h1234, 64'h1, 16'd1};                                                  // XOR -> 0, bad
    vt[4] = '{2'b10, 64'hFF00_FF00_FF00_FF00, 64'h00FF_00FF_00FF_00FF, 64'hFFFF_FFFF_FFFF_FFFF, 16'd1};  // XOR -> F..F
    vt[5] = '{2'b01, 64'hF0, 64'h0F, 64'hFF, 16'd0};                                                     // OR  -> FF
    vt[6] = '{2'b11, 64'h0, 64'h0, 64'h0, 16'd1};                                                        // NOR -> F..F, bad
    vt[7] = '{2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 16'd1};  // OR  -> F..F
    vt[8] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1, 16'd2};                                      // NOR -> 0, bad

    // n, first, toggle, err, pass, ffv, ffi, ffe, ffa
    rt[0] = '{2, 0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 64'h0, 64'h0};
    rt[1] = '{3, 2, 1'b0, 16'd1, 1'b0, 1'b1, 16'd1, 64'h0, 64'h1};
    rt[2] = '{4, 5, 1'b1, 16'd2, 1'b0, 1'b1, 16'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

    vif.in_valid = 1'b0; vif.in_op = '0; vif.in_a = '0; vif.in_b = '0; vif.in_result = '0;
    sif.in_valid = 1'b0; sif.in_op = '0; sif.in_a = '0; sif.in_b = '0; sif.in_result = '0;

    // Reset state
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk_all_zero("idle");

    // Table-driven runs
    for (int r = 0; r < 3; r++) begin
      start   = 1'b1;
      num_vec = CW'(rt[r].n);
      step();
      start   = 1'b0;
      num_vec = CW'($urandom);
      chk("run_start_in_ready",  W'(vif.in_ready), 1);
      chk("run_start_busy",      W'(busy),         1);
      chk("run_start_done",      W'(done),         0);
      chk("run_start_vec_count", W'(vec_count),    0);
      chk("run_start_err_count", W'(err_count),    0);
      chk("run_start_ff_valid",  W'(ff_valid),     0);
      for (int k = 0; k < rt[r].n; k++) begin
        drive_vec(vt[rt[r].first + k]);
        step();
        drive_idle();
        $display("run=%0d vec=%0d op=%0d vec_count=%0d err_count=%0d done=%0d",
                 r, k, vt[rt[r].first + k].op, vec_count, err_count, done);
        chk("xfer_vec_count", W'(vec_count), W'(k + 1));
        chk("xfer_err_count", W'(err_count), W'(vt[rt[r].first + k].exp_err));
        if (rt[r].toggle && (k < rt[r].n - 1)) begin
          step();
          chk("idle_vec_count", W'(vec_count), W'(k + 1));
          chk("idle_busy",      W'(busy),      1);
        end
      end
      chk("end_done",        W'(done),         1);
      chk("end_pass",        W'(pass),         W'(rt[r].exp_pass));
      chk("end_in_ready",    W'(vif.in_ready), 0);
      chk("end_busy",        W'(busy),         0);
      chk("end_vec_count",   W'(vec_count),    W'(rt[r].n));
      chk("end_err_count",   W'(err_count),    W'(rt[r].exp_err));
      chk("end_ff_valid",    W'(ff_valid),     FFEN ? W'(rt[r].ffv) : '0);
      chk("end_ff_index",    W'(ff_index),     FFEN ? W'(rt[r].ffi) : '0);
      chk("end_ff_expected", ff_expected,      FFEN ? rt[r].ffe : '0);
      chk("end_ff_actual",   ff_actual,        FFEN ? rt[r].ffa : '0);
      // DONE holds, and a stray valid is not consumed
      vif.in_valid = 1'b1;
      step();
      vif.in_valid = 1'b0;
      chk("hold_done",      W'(done),      1);
      chk("hold_vec_count", W'(vec_count), W'(rt[r].n));
    end

    // Zero-length run from DONE (previous err_count was 2)
    start   = 1'b1;
    num_vec = '0;
    vif.in_valid = 1'b1;
    step();
    start = 1'b0;
    $display("run=zero done=%0d pass=%0d in_ready=%0d", done, pass, vif.in_ready);
    chk("zero_done",      W'(done),      1);
    chk("zero_pass",      W'(pass),      1);
    chk("zero_err_count", W'(err_count), 0);
    chk("zero_vec_count", W'(vec_count), 0);
    chk("zero_ff_valid",  W'(ff_valid),  0);
    for (int i = 0; i < 3; i++) begin
      chk("zero_in_ready", W'(vif.in_ready), 0);
      step();
    end
    chk("zero_vec_count_hold", W'(vec_count), 0);
    vif.in_valid = 1'b0;

    // Saturation on the 4-bit instance: 15 NOR vectors, all wrong
    s_start   = 1'b1;
    s_num_vec = 4'd15;
    step();
    s_start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      sif.in_valid  = 1'b1;
      sif.in_op     = 2'b11;
      sif.in_a      = W'(k);
      sif.in_b      = '0;
      sif.in_result = W'(k);       // NOR(k,0) = ~k, never equal to k
      step();
      sif.in_valid = 1'b0;
      $display("run=sat vec=%0d vec_count=%0d err_count=%0d", k, s_vec_count, s_err_count);
      chk("sat_err_count", W'(s_err_count), W'(k + 1));
    end
    chk("sat_done",      W'(s_done),      1);
    chk("sat_pass",      W'(s_pass),      0);
    chk("sat_vec_count", W'(s_vec_count), 15);
    chk("sat_ff_index",  W'(s_ff_index),  0);
    chk("sat_ff_expected", s_ff_expected, FFEN ? 64'hFFFF_FFFF_FFFF_FFFF : '0);
    sif.in_valid = 1'b1;
    step();
    step();
    sif.in_valid = 1'b0;
    chk("sat_err_hold", W'(s_err_count), 15);

    // Reset mid-run after 2 of 5 vectors
    start   = 1'b1;
    num_vec = 16'd5;
    step();
    start = 1'b0;
    drive_vec(vt[3]);
    step();
    drive_vec(vt[0]);
    step();
    drive_idle();
    $display("run=abort vec_count=%0d err_count=%0d", vec_count, err_count);
    chk("abort_pre_vec_count", W'(vec_count), 2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    step();
    rst_n = 1'b1;
    step();
    chk_all_zero("abort_idle");

    // Fresh run; a start mid-RUN (with num_vec=0) must be ignored
    start   = 1'b1;
    num_vec = 16'd2;
    step();
    start   = 1'b0;
    start   = 1'b1;
    num_vec = '0;
    step();
    start = 1'b0;
    chk("ignore_busy",     W'(busy),         1);
    chk("ignore_done",     W'(done),         0);
    chk("ignore_in_ready", W'(vif.in_ready), 1);
    drive_vec(vt[0]);
    step();
    drive_vec(vt[1]);
    step();
    drive_idle();
    $display("run=fresh vec_count=%0d err_count=%0d done=%0d pass=%0d", vec_count, err_count, done, pass);
    chk("fresh_done",      W'(done),      1);
    chk("fresh_pass",      W'(pass),      1);
    chk("fresh_vec_count", W'(vec_count), 2);
    chk("fresh_err_count", W'(err_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
